// File: rtl/fft_reorder.sv
// Bit-reversal reorder buffer behind the 64-point FFT.
// Ping-pong banks: one fills in bit-reversed order while the other drains in natural order.
module fft_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idata_en,
  input  logic [WIDTH-1:0] idata_r,
  input  logic [WIDTH-1:0] idata_i,
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i
);

  localparam int LOG2N = $clog2(N);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] x
  );
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = x[LOG2N-1-b];
    end
    return r;
  endfunction

  logic [2*WIDTH-1:0] bank0_q [N];
  logic [2*WIDTH-1:0] bank1_q [N];

  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wsel_q, wsel_d;
  logic             frame_done;
  logic [LOG2N-1:0] waddr;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rsel_q, rsel_d;
  logic             emit;
  logic [2*WIDTH-1:0] rdata;

  logic             oen_q;
  logic [WIDTH-1:0] or_q;
  logic [WIDTH-1:0] oi_q;

  // Write-side counter and bank select; frame ends when the last index is taken.
  always_comb begin
    wcnt_d     = wcnt_q;
    wsel_d     = wsel_q;
    frame_done = 1'b0;
    waddr      = bitrev(wcnt_q);
    if (idata_en) begin
      wcnt_d = wcnt_q + LOG2N'(1);
      if (wcnt_q == LAST) begin
        wsel_d     = ~wsel_q;
        frame_done = 1'b1;
      end
    end
  end

  // Write-side state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt_q <= '0;
      wsel_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wsel_q <= wsel_d;
    end
  end

  // Sample storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (idata_en) begin
      if (wsel_q) begin
        bank1_q[waddr] <= {idata_r, idata_i};
      end else begin
        bank0_q[waddr] <= {idata_r, idata_i};
      end
    end
  end

  assign rdata = rsel_q ? bank1_q[rcnt_q] : bank0_q[rcnt_q];

  // Read FSM next state: drain N words, chain straight into a frame finishing now.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rsel_d  = rsel_q;
    emit    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_done) begin
          state_d = S_READ;
          rsel_d  = wsel_q;
          rcnt_d  = '0;
        end
      end
      S_READ: begin
        emit   = 1'b1;
        rcnt_d = rcnt_q + LOG2N'(1);
        if (rcnt_q == LAST) begin
          if (frame_done) begin
            rsel_d = wsel_q;
            rcnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rsel_q  <= rsel_d;
    end
  end

  // Registered outputs, forced to zero when not valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      oen_q <= 1'b0;
      or_q  <= '0;
      oi_q  <= '0;
    end else begin
      oen_q <= emit;
      or_q  <= emit ? rdata[2*WIDTH-1:WIDTH] : '0;
      oi_q  <= emit ? rdata[WIDTH-1:0] : '0;
    end
  end

  assign odata_en = oen_q;
  assign odata_r  = or_q;
  assign odata_i  = oi_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder.
// Model reorders whole frames with arrays; monitor checks data and cycle.
module tb_fft_reorder;

  localparam int N = 64;
  localparam int W = 16;

  logic         clock;
  logic         rst_n;
  logic         idata_en;
  logic [W-1:0] idata_r;
  logic [W-1:0] idata_i;
  logic         odata_en;
  logic [W-1:0] odata_r;
  logic [W-1:0] odata_i;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] i;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wc = 0;
  logic [W-1:0] fr_r [N];
  logic [W-1:0] fr_i [N];

  fft_reorder #(.N(N), .WIDTH(W)) dut (
    .clock    (clock),
    .reset    (rst_n),
    .idata_en (idata_en),
    .idata_r  (idata_r),
    .idata_i  (idata_i),
    .odata_en (odata_en),
    .odata_r  (odata_r),
    .odata_i  (odata_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int brev(input int x);
    int r = 0;
    for (int b = 0; b < 6; b++) begin
      r = r * 2 + ((x >> b) & 1);
    end
    return r;
  endfunction

  // Reference model: gather a frame; on its last sample, schedule
  // natural-order bin k one cycle later plus k.
  always @(posedge clock) begin
    cyc++;
    if (!rst_n) begin
      wc = 0;
    end else if (idata_en) begin
      fr_r[wc] = idata_r;
      fr_i[wc] = idata_i;
      wc++;
      if (wc == N) begin
        for (int k = 0; k < N; k++) begin
          exp_t e;
          e.r   = fr_r[brev(k)];
          e.i   = fr_i[brev(k)];
          e.cyc = cyc + 1 + k;
          sb.push_back(e);
        end
        wc = 0;
      end
    end
  end

  // Monitor away from the active edge.
  always @(negedge clock) begin
    if (odata_en) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out cyc=%0d r=%0d i=%0d", cyc, odata_r, odata_i);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (odata_r !== e.r || odata_i !== e.i || cyc != e.cyc) begin
          failures++;
          $display("FAIL out_data got r=%0d i=%0d cyc=%0d want r=%0d i=%0d cyc=%0d",
                   odata_r, odata_i, cyc, e.r, e.i, e.cyc);
        end
      end
    end else begin
      checks++;
      if (odata_r !== '0 || odata_i !== '0) begin
        failures++;
        $display("FAIL idle_zero got r=%0d i=%0d want 0 0", odata_r, odata_i);
      end
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_out cyc=%0d got en=0 want en=1 r=%0d",
                 cyc, sb[0].r);
        void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input logic en, input logic [W-1:0] r,
                       input logic [W-1:0] i);
    idata_en = en;
    idata_r  = r;
    idata_i  = i;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, W'($urandom), W'($urandom));
  endtask

  task automatic ramp(input int off);
    for (int j = 0; j < N; j++) begin
      drive(1'b1, W'(j + off), W'(-(j + off)));
    end
  endtask

  task automatic rnd_frame(input int gap_pct);
    for (int j = 0; j < N; j++) begin
      while ($urandom_range(99) < gap_pct) idle(1);
      drive(1'b1, W'($urandom), W'($urandom));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (odata_en !== 1'b0 || odata_r !== '0 || odata_i !== '0) begin
      failures++;
      $display("FAIL async_reset got en=%0b r=%0d i=%0d want 0 0 0",
               odata_en, odata_r, odata_i);
    end
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    idata_en = 1'b0;
    idata_r  = '0;
    idata_i  = '0;
    repeat (3) @(posedge clock);
    #1;
    rst_n = 1'b1;
    idle(2);

    ramp(0);
    idle(N + 4);

    ramp(0);
    ramp(100);
    ramp(200);
    idle(N + 4);

    for (int j = 0; j < N; j++) begin
      drive(1'b1, W'(j), W'(-j));
      idle(1);
    end
    idle(N + 4);

    ramp(0);
    idle(21);
    do_reset();
    rnd_frame(0);
    idle(N + 4);

    for (int j = 0; j < 30; j++) drive(1'b1, W'($urandom), W'($urandom));
    do_reset();
    ramp(300);
    idle(N + 4);

    for (int f = 0; f < 4; f++) rnd_frame(30);
    for (int f = 0; f < 3; f++) rnd_frame(0);
    idle(N + 4);

    for (int c = 0; c < 200 && sb.size() > 0; c++) idle(1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_reorder.md
# fft_reorder

Bit-reversal reorder buffer placed directly downstream of the 64-point R2²SDF FFT. The FFT emits each frame in bit-reversed index order: output j carries bin X[bitrev(j)]. This block collects one frame and re-emits it in natural bin order (X[0]..X[N-1]). It uses a ping-pong pair of N-word banks, so back-to-back frames stream through with no gaps and no stalls.

## Interface
- N, 64: frame length in complex samples. Must be a power of 2, at least 4. LOG2N = log2(N) is derived internally.
- WIDTH, 16: bit width of each real or imaginary component.

- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Logic is held in reset while the port is 0.
- idata_en  in  1  input sample valid; one complex sample accepted per cycle while high.
- idata_r  in  WIDTH  input real part, bit-reversed frame order.
- idata_i  in  WIDTH  input imaginary part.
- odata_en  out  1  output sample valid.
- odata_r  out  WIDTH  output real part, natural order.
- odata_i  out  WIDTH  output imaginary part.

## Operation
- Storage: two banks, bank0 and bank1, each N x (2*WIDTH). Data passes through unmodified: no scaling, rounding or sign change.
- Write side:
  - wsel selects the write bank; wcnt is a LOG2N-bit counter.
  - On a clock edge with idata_en=1, the sample is written to bank[wsel] at address bitrev(wcnt), then wcnt increments.
  - When wcnt=N-1 is consumed, wcnt wraps to 0, wsel toggles and a frame-done pulse is raised.
  - Gaps (idata_en=0) are allowed anywhere; wcnt simply holds.
- Read side state machine:
  - IDLE: odata_en=0. On frame-done, go to READ with rsel = the bank just filled and rcnt=0.
  - READ: each cycle, output bank[rsel][rcnt] on registered outputs, then increment rcnt. After rcnt=N-1 is emitted:
    - if a frame-done occurs in that same cycle, restart READ on the other bank with rcnt=0;
    - otherwise return to IDLE.
- Read timing is unconditional: once started, N consecutive valid cycles are emitted regardless of idata_en.
- Overflow cannot occur. A new frame needs at least N enabled cycles, so it cannot complete before the current read finishes. The write bank is never the bank being read.
- bitrev(x) reverses the LOG2N bits of x (for N=64, bit5..bit0 becomes bit0..bit5).
- odata_r/odata_i are 0 whenever odata_en=0.

## Timing
- Reset values:
  - odata_en=0, odata_r=0, odata_i=0.
  - wcnt=0, wsel=0, rcnt=0, state IDLE.
  - Bank contents are not reset (don't care).
- Latency: let cycle t be the edge capturing the N-th sample of a frame. Natural-order sample k is presented with odata_en=1 in cycle t+1+k, for k=0..N-1.
- Back-to-back input (idata_en high continuously): odata_en, once high, stays high continuously with no bubble at frame boundaries.
- Frame completing exactly on the read's last cycle: the next read starts in the immediately following cycle.
- Reset asserted mid-frame or mid-read:
  - the partial input frame and the in-progress output are discarded;
  - the outputs go to 0 asynchronously.
  - After reset deasserts, the first idata_en sample is treated as index 0 of a new frame.
- Reset deassertion: synchronized release by the surrounding system; no internal synchronizer.

## Test plan
- Single frame: N=64, idata_en high 64 cycles, idata_r=j, idata_i=-j for input index j.
  - Expect odata_en high for exactly 64 cycles starting 1 cycle after the last input.
  - Output k has odata_r=bitrev6(k): k=0 gives 0, k=1 gives 32, k=2 gives 16, k=63 gives 63. odata_i is the negation.
- Back-to-back: 3 consecutive frames with distinct offsets (0, 100, 200 added to j).
  - Expect 192 contiguous odata_en cycles with no bubble.
  - Each frame reordered correctly; no cross-frame mixing.
- Gapped input: idata_en toggles 1,0,1,0 across a frame (128 cycles).
  - Output matches the single-frame case.
  - odata_en starts 1 cycle after the 64th accepted sample.
- Reset mid-read: assert reset at output k=20.
  - odata_en, odata_r and odata_i drop to 0 immediately.
  - A fresh frame afterwards reorders correctly from index 0.
- Reset mid-write: reset after 30 samples, then send one full frame.
  - Exactly 64 output cycles, all from the new frame.
- FFT chain: connect the 64-point FFT to this block and drive an impulse at sample 0 with amplitude 1000.
  - All 64 natural-order bins are equal (flat spectrum) within FFT rounding.
